ex_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the execute stage. It resolves four things each cycle: the branch/jump redirect produced by EX, load-use hazards between ID and EX, multi-cycle EX operations (divider-class units) through a start/done handshake, and external bus stalls. It produces per-stage stall and flush controls plus the PC redirect, and sits between the IF/ID/EX pipeline registers and the PC generator.

---
 rtl/ex_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage sequencing controller: jump redirect, load-use interlock,
// multi-cycle op start/done/timeout handshake and external bus stalls.
module ex_pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_rmem,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mc_op,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_use,
  input  logic        id_rs2_use,
  input  logic        mc_done,
  input  logic        ext_stall,
  output logic        mc_start,
  output logic        mc_abort,
  output logic        mc_result_sel,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        redirect,
  output logic [31:0] redirect_addr,
  output logic        mc_err
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             load_use_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Register 0 is hard-wired, so a load into it never creates a hazard.
  assign load_use_c = ex_rmem && (ex_rd != 5'd0) &&
                      ((id_rs1_use && (id_rs1 == ex_rd)) ||
                       (id_rs2_use && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    mc_start      = 1'b0;
    mc_abort      = 1'b0;
    mc_result_sel = 1'b0;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    // Outputs are same-cycle decodes, so they are gated off while in reset.
    if (rst_n) begin
      if (ext_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (ex_mc_op) begin
              mc_start = 1'b1;
              stall_if = 1'b1;
              stall_id = 1'b1;
              stall_ex = 1'b1;
              state_d  = MC_WAIT;
              cnt_d    = '0;
            end else if (ex_jump) begin
              redirect      = 1'b1;
              redirect_addr = ex_jump_addr;
              flush_id      = 1'b1;
            end else if (load_use_c) begin
              stall_if = 1'b1;
              stall_id = 1'b1;
              flush_id = 1'b1;
            end
          end
          MC_WAIT: begin
            if (mc_done) begin
              mc_result_sel = 1'b1;
              state_d       = RUN;
            end else if (cnt_q == CNT_LAST) begin
              mc_abort = 1'b1;
              flush_ex = 1'b1;
              err_d    = 1'b1;
              state_d  = RUN;
            end else begin
              stall_if = 1'b1;
              stall_id = 1'b1;
              stall_ex = 1'b1;
              if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  assign mc_err = err_q;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Bench for ex_pipe_ctrl: directed scenarios then random traffic, every cycle
// compared against a cycle-level behavioural model of the controller.
module tb_ex_pipe_ctrl;
  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_jump;
  logic [31:0] ex_jump_addr;
  logic        ex_rmem;
  logic [4:0]  ex_rd;
  logic        ex_mc_op;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_use, id_rs2_use;
  logic        mc_done, ext_stall;
  logic        mc_start, mc_abort, mc_result_sel;
  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex;
  logic        redirect, mc_err;
  logic [31:0] redirect_addr;

  always #5 clk = ~clk;

  ex_pipe_ctrl #(.MC_TIMEOUT(T), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
    .ex_rmem(ex_rmem), .ex_rd(ex_rd), .ex_mc_op(ex_mc_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .mc_done(mc_done), .ext_stall(ext_stall), .mc_start(mc_start), .mc_abort(mc_abort),
    .mc_result_sel(mc_result_sel), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .flush_id(flush_id), .flush_ex(flush_ex),
    .redirect(redirect), .redirect_addr(redirect_addr), .mc_err(mc_err)
  );

  // Model: are we waiting on the multi-cycle unit, how many wait cycles have
  // already elapsed, and has any operation ever timed out.
  bit          m_busy;
  int unsigned m_elapsed;
  bit          m_err;
  int unsigned passes = 0, total = 0, starts_seen = 0;

  function automatic logic [9:0] model_flags();
    logic st = 0, ab = 0, sel = 0, sif = 0, sid = 0, sex = 0, fid = 0, fex = 0, red = 0;
    logic hazard;
    hazard = ex_rmem && ex_rd != 0 &&
             ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
    if (rst_n) begin
      if (ext_stall) {sif, sid, sex} = 3'b111;
      else if (!m_busy) begin
        if (ex_mc_op)     begin st = 1; {sif, sid, sex} = 3'b111; end
        else if (ex_jump) begin red = 1; fid = 1; end
        else if (hazard)  begin sif = 1; sid = 1; fid = 1; end
      end else begin
        if (mc_done)                 sel = 1;
        else if (m_elapsed == T - 1) begin ab = 1; fex = 1; end
        else                         {sif, sid, sex} = 3'b111;
      end
    end
    return {st, ab, sel, sif, sid, sex, fid, fex, red, m_err};
  endfunction

  task automatic check(input string tag);
    logic [9:0]  exp_f, got_f;
    logic [31:0] exp_a;
    #2;
    if (!rst_n) begin m_busy = 0; m_elapsed = 0; m_err = 0; end
    exp_f = model_flags();
    exp_a = (exp_f[1]) ? ex_jump_addr : 32'd0;
    got_f = {mc_start, mc_abort, mc_result_sel, stall_if, stall_id, stall_ex,
             flush_id, flush_ex, redirect, mc_err};
    if (mc_start === 1'b1) starts_seen++;
    total++;
    assert (got_f === exp_f && redirect_addr === exp_a) passes++;
    else $error("FAIL %s: got flags=%b addr=%h expected flags=%b addr=%h",
                tag, got_f, redirect_addr, exp_f, exp_a);
  endtask

  task automatic tick();
    bit n_busy = m_busy, n_err = m_err;
    int unsigned n_el = m_elapsed;
    if (!rst_n) begin n_busy = 0; n_el = 0; n_err = 0; end
    else if (!ext_stall) begin
      if (!m_busy) begin
        if (ex_mc_op) begin n_busy = 1; n_el = 0; end
      end else if (mc_done) n_busy = 0;
      else if (m_elapsed == T - 1) begin n_busy = 0; n_err = 1; end
      else n_el = m_elapsed + 1;
    end
    @(posedge clk);
    #1;
    m_busy = n_busy; m_elapsed = n_el; m_err = n_err;
  endtask

  task automatic cyc(input string tag);
    check(tag);
    tick();
  endtask

  task automatic idle();
    ex_jump = 0; ex_jump_addr = 32'h0; ex_rmem = 0; ex_rd = 0; ex_mc_op = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    mc_done = 0; ext_stall = 0;
  endtask

  initial begin
    m_busy = 0; m_elapsed = 0; m_err = 0;
    idle();
    rst_n = 0; ex_jump = 1; ex_jump_addr = 32'hDEAD_BEEF; ex_mc_op = 1;
    #1;
    cyc("reset_hold0");
    cyc("reset_hold1");
    rst_n = 1; idle();
    cyc("post_reset_idle");

    ex_jump = 1; ex_jump_addr = 32'h0000_0100;
    cyc("jump");
    idle();
    cyc("after_jump");

    ex_rmem = 1; ex_rd = 5; id_rs2 = 5; id_rs2_use = 1;
    cyc("load_use_rs2");
    ex_rd = 0; id_rs2 = 0;
    cyc("load_use_rd0");
    ex_rd = 5; id_rs2 = 5; ex_jump = 1; ex_jump_addr = 32'h0000_2000;
    cyc("load_use_masked_by_jump");
    idle(); ex_rmem = 1; ex_rd = 7; id_rs1 = 7; id_rs1_use = 0;
    cyc("load_use_rs1_unused");
    id_rs1_use = 1;
    cyc("load_use_rs1");
    idle();

    starts_seen = 0;
    ex_mc_op = 1; ex_jump = 1; ex_jump_addr = 32'h0000_4444;
    cyc("mc_start");
    for (int i = 1; i < 33; i++) cyc("mc_wait");
    mc_done = 1;
    cyc("mc_done");
    idle();
    cyc("mc_back_in_run");
    total++;
    assert (starts_seen === 1) passes++;
    else $error("FAIL mc_start_count: got %0d expected 1", starts_seen);

    ex_mc_op = 1;
    cyc("mc2_start");
    for (int i = 0; i < 5; i++) cyc("mc2_wait");
    ext_stall = 1; mc_done = 1;
    for (int i = 0; i < 3; i++) cyc("mc2_ext_stall_done");
    ext_stall = 0; mc_done = 0;
    cyc("mc2_wait_after_stall");
    cyc("mc2_wait_after_stall");
    mc_done = 1;
    cyc("mc2_done");
    idle();

    ex_mc_op = 1;
    cyc("mc3_start");
    for (int i = 0; i < int'(T) - 1; i++) cyc("mc3_wait");
    cyc("mc3_timeout_abort");
    ex_mc_op = 0;
    cyc("mc3_err_sticky");
    mc_done = 1;
    cyc("mc_done_in_run_ignored");
    mc_done = 0; ext_stall = 1;
    cyc("err_held_in_ext_stall");
    idle();

    ex_mc_op = 1;
    cyc("mc4_start");
    cyc("mc4_wait");
    rst_n = 0;
    cyc("mc4_reset_mid_wait");
    rst_n = 1; ex_mc_op = 0;
    cyc("mc4_run_after_reset");

    for (int n = 0; n < 3000; n++) begin
      ex_jump      = ($urandom_range(0, 3) == 0);
      ex_jump_addr = $urandom;
      ex_rmem      = ($urandom_range(0, 2) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_mc_op     = ($urandom_range(0, 7) == 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rs1_use   = 1'($urandom);
      id_rs2_use   = 1'($urandom);
      mc_done      = ($urandom_range(0, 29) == 0);
      ext_stall    = ($urandom_range(0, 5) == 0);
      rst_n        = ($urandom_range(0, 399) != 0);
      cyc("random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
